// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: STEP multiplier bits per clock, unsigned or
// two's-complement operands, valid/ready handshakes on request and result.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int N  = WIDTH / STEP;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_sum;

    // Magnitude fits in WIDTH bits even for the most-negative operand (2^(W-1)).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (is_signed && sv < 0)
            return ~v + WIDTH'(1);
        return v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                 input logic          neg);
        return neg ? (~mag + PW'(1)) : mag;
    endfunction

    always_comb begin
        partial = mcand_q * PW'(mplier_q[STEP-1:0]);
        acc_sum = acc_q + partial;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    mcand_d  = PW'(magnitude(a, signed_mode));
                    mplier_d = magnitude(b, signed_mode);
                    sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(N);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q - CW'(1);
                // Last window: publish the signed-corrected product directly.
                if (cnt_q == CW'(1)) begin
                    p_d     = apply_sign(acc_sum, sign_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign p           = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: an 8x8/STEP=1 and a 16x16/STEP=4 instance,
// directed cases then random ops with stalls, checked through a result scoreboard.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sv8 = 0, sm8 = 0, rr8 = 0, sr8, rv8, busy8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    logic        sv16 = 0, sm16 = 0, rr16 = 0, sr16, rv16, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    seq_shift_add_multiplier #(.WIDTH(8), .STEP(1)) u_m8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .signed_mode(sm8), .a(a8), .b(b8), .res_valid(rv8), .res_ready(rr8),
        .p(p8), .busy(busy8));

    seq_shift_add_multiplier #(.WIDTH(16), .STEP(4)) u_m16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16),
        .signed_mode(sm16), .a(a16), .b(b16), .res_valid(rv16), .res_ready(rr16),
        .p(p16), .busy(busy16));

    int passed = 0;
    int total  = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input bit sm);
        longint m, ma, mb, pr;
        m  = (longint'(1) << w) - 1;
        ma = longint'(av) & m;
        mb = longint'(bv) & m;
        if (sm && ma[w-1]) ma = ma - (longint'(1) << w);
        if (sm && mb[w-1]) mb = mb - (longint'(1) << w);
        pr = ma * mb;
        return 32'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic drv(input int sel, input logic sv, input logic [15:0] av,
                       input logic [15:0] bv, input logic sm);
        if (sel == 0) begin
            sv8 = sv; a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm;
        end else begin
            sv16 = sv; a16 = av; b16 = bv; sm16 = sm;
        end
    endtask

    task automatic set_rr(input int sel, input logic v);
        if (sel == 0) rr8 = v; else rr16 = v;
    endtask

    function automatic logic rd_rv(input int sel);
        return (sel == 0) ? rv8 : rv16;
    endfunction
    function automatic logic rd_sr(input int sel);
        return (sel == 0) ? sr8 : sr16;
    endfunction
    function automatic logic rd_busy(input int sel);
        return (sel == 0) ? busy8 : busy16;
    endfunction
    function automatic logic [31:0] rd_p(input int sel);
        return (sel == 0) ? {16'h0, p8} : p16;
    endfunction

    // Entered and left #1 after a rising edge with the selected instance in IDLE.
    task automatic op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                      input bit sm, input int stall, input bit junk);
        int n, w, lat;
        logic [31:0] held, exp;
        n = (sel == 0) ? 8 : 4;
        w = (sel == 0) ? 8 : 16;
        lat = 0;
        chk("start_ready_idle", rd_sr(sel), 1'b1);
        drv(sel, 1'b1, av, bv, sm);
        set_rr(sel, stall == 0);
        sb.push_back(ref_mul(w, av, bv, sm));
        @(posedge clk); #1;
        drv(sel, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("busy_after_accept", rd_busy(sel), 1'b1);
        chk("start_ready_run", rd_sr(sel), 1'b0);
        while (!rd_rv(sel) && lat < 40) begin
            if (junk) drv(sel, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, n);
        held = rd_p(sel);
        for (int i = 0; i < stall; i++) begin
            if (junk || i == 2) drv(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            chk("stall_res_valid", rd_rv(sel), 1'b1);
            chk("stall_p_stable", rd_p(sel), held);
            chk("stall_start_ready", rd_sr(sel), 1'b0);
        end
        set_rr(sel, 1'b1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            exp = 32'h0;
        end else begin
            exp = sb.pop_front();
        end
        chk("product", rd_p(sel), exp);
        @(posedge clk); #1;
        drv(sel, 1'b0, 16'h0, 16'h0, 1'b0);
        set_rr(sel, 1'b0);
        chk("start_ready_after_hs", rd_sr(sel), 1'b1);
        chk("res_valid_after_hs", rd_rv(sel), 1'b0);
        chk("p_kept_after_hs", rd_p(sel), exp);
    endtask

    initial begin
        #2;
        chk("rst_start_ready8", sr8, 1'b1);
        chk("rst_res_valid8", rv8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_p8", p8, 16'h0);
        chk("rst_start_ready16", sr16, 1'b1);
        chk("rst_res_valid16", rv16, 1'b0);
        chk("rst_busy16", busy16, 1'b0);
        chk("rst_p16", p16, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        op(0, 16'd255, 16'd255, 1'b0, 0, 1'b0);
        chk("u_255x255", p8, 16'hFE01);
        op(0, 16'h80, 16'h80, 1'b1, 0, 1'b0);
        chk("s_m128xm128", p8, 16'h4000);
        op(0, 16'hFD, 16'd5, 1'b1, 0, 1'b0);
        chk("s_m3x5", p8, 16'hFFF1);
        op(0, 16'd253, 16'd5, 1'b0, 0, 1'b0);
        chk("u_253x5", p8, 16'h04F1);

        op(0, 16'd12, 16'd11, 1'b0, 5, 1'b0);
        chk("bp_12x11", p8, 16'd132);
        op(0, 16'd200, 16'd3, 1'b0, 0, 1'b0);
        chk("after_bp_200x3", p8, 16'd600);

        // Abort mid-RUN: reset after the third RUN edge.
        drv(0, 1'b1, 16'd100, 16'd3, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_res_valid", rv8, 1'b0);
        chk("abort_p", p8, 16'h0);
        chk("abort_start_ready", sr8, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, 16'd7, 16'd6, 1'b0, 0, 1'b0);
        chk("after_abort_7x6", p8, 16'd42);

        op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
        chk("u16_max", p16, 32'hFFFE0001);
        op(1, 16'hFFFF, 16'h8000, 1'b1, 2, 1'b0);
        chk("s16_m1xm32768", p16, 32'h00008000);
        op(1, 16'h8000, 16'h8000, 1'b1, 0, 1'b0);
        chk("s16_min_sq", p16, 32'h40000000);
        op(1, 16'h0, 16'h1234, 1'b1, 0, 1'b0);
        chk("s16_zero", p16, 32'h0);

        for (int i = 0; i < 150; i++)
            op(0, 16'($urandom), 16'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
        for (int i = 0; i < 150; i++)
            op(1, 16'($urandom), 16'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
